// File: rtl/cheri_err_pkg.sv
// CHERI error monitor shared types: exception cause enum, event record and cause names for reporting.
package cheri_err_pkg;

  localparam int unsigned NumCheriErr = 9;
  localparam int unsigned EvtIdxW     = $clog2(NumCheriErr);
  localparam int unsigned EvtTsW      = 48;

  typedef enum logic [3:0] {
    Bounds              = 4'd0,
    Tag                 = 4'd1,
    Seal                = 4'd2,
    PermitExecute       = 4'd3,
    PermitLoad          = 4'd4,
    PermitStore         = 4'd5,
    PermitStoreCap      = 4'd6,
    PermitStoreLocalCap = 4'd7,
    PermitAccSysRegs    = 4'd8
  } cheri_err_e;

  typedef struct packed {
    logic [EvtIdxW-1:0] idx;
    logic [EvtTsW-1:0]  ts;
  } cheri_err_event_t;

  localparam string CheriErrNames [NumCheriErr] = '{
    "Bounds", "Tag", "Seal", "PermitExecute", "PermitLoad",
    "PermitStore", "PermitStoreCap", "PermitStoreLocalCap", "PermitAccSysRegs"
  };

endpackage

// File: rtl/cheri_err_episode.sv
// Per-line episode tracker: an episode opens on a high sample and closes after GapCycles
// consecutive low samples; count saturates at all-ones. clear_i wins over any update.
module cheri_err_episode #(
  parameter int unsigned CountWidth = 16,
  parameter int unsigned GapCycles  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  err_i,
  output logic [CountWidth-1:0] count_o
);

  localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

  logic                  active_q;
  logic [GapW-1:0]       gap_q;
  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      gap_q    <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      active_q <= 1'b0;
      gap_q    <= '0;
      count_q  <= '0;
    end else if (!active_q) begin
      if (err_i) begin
        active_q <= 1'b1;
        gap_q    <= '0;
        if (count_q != '1) count_q <= count_q + CountWidth'(1);
      end
    end else if (err_i) begin
      gap_q <= '0;
    end else if (gap_q == GapW'(GapCycles - 1)) begin
      // Modulation gaps shorter than GapCycles stay inside the same episode.
      active_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      gap_q <= gap_q + GapW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prim_fifo_sync.sv
// Synchronous show-ahead FIFO with flush; latency 1 cycle (Pass=0) or 0 (Pass=1, empty).
// Backpressure: wready_o low only when full and not popping; a pop frees a slot for a same-cycle push.
module prim_fifo_sync #(
  parameter int unsigned Width = 8,
  parameter bit          Pass  = 1'b0,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             empty, full, pass_thru, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CntW'(Depth));
  assign pass_thru = Pass && empty && wvalid_i;
  assign rvalid_o  = !empty || pass_thru;
  assign rdata_o   = (Pass && empty) ? wdata_i : mem_q[rptr_q];
  assign wready_o  = !full || rready_i;
  assign do_pop    = rready_i && !empty;
  assign do_push   = wvalid_i && wready_o && !(pass_thru && rready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cheri_err_monitor.sv
// Turns modulated CHERI error lines into sticky flags, episode counts and a timestamped event stream.
// Event latency: sample at edge N -> event_valid_o after edge N+1; full FIFO holds events as pending bits.
module cheri_err_monitor
  import cheri_err_pkg::*;
#(
  parameter int unsigned ErrWidth   = NumCheriErr,
  parameter int unsigned TsWidth    = 48,
  parameter int unsigned CountWidth = 16,
  parameter int unsigned GapCycles  = 16,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ErrWidth-1:0]            cheri_err_i,
  input  logic                           clear_i,
  output logic [ErrWidth-1:0]            errored_o,
  output logic                           any_err_o,
  output logic [ErrWidth*CountWidth-1:0] count_o,
  output logic                           event_valid_o,
  input  logic                           event_ready_i,
  output logic [$clog2(ErrWidth)-1:0]    event_idx_o,
  output logic [TsWidth-1:0]             event_ts_o
);

  localparam int unsigned IdxW = $clog2(ErrWidth);
  localparam int unsigned EvtW = IdxW + TsWidth;

  logic [TsWidth-1:0]  ts_q;
  logic [ErrWidth-1:0] errored_q, pending_q, new_err, push_sel, push_clr;
  logic [TsWidth-1:0]  ts_first_q [ErrWidth];
  logic [IdxW-1:0]     push_idx;
  logic [TsWidth-1:0]  push_ts;
  logic                push_any, fifo_wvalid, fifo_wready, push_fire;
  logic [EvtW-1:0]     fifo_rdata;

  assign new_err = cheri_err_i & ~errored_q;

  // Lowest-index pending line wins the single push slot each cycle.
  always_comb begin
    push_any = 1'b0;
    push_idx = '0;
    push_ts  = '0;
    push_sel = '0;
    for (int i = int'(ErrWidth) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_any    = 1'b1;
        push_idx    = IdxW'(i);
        push_ts     = ts_first_q[i];
        push_sel    = '0;
        push_sel[i] = 1'b1;
      end
    end
  end

  assign fifo_wvalid = push_any && !clear_i;
  assign push_fire   = fifo_wvalid && fifo_wready;
  assign push_clr    = push_fire ? push_sel : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TsWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      errored_q <= '0;
      pending_q <= '0;
      for (int i = 0; i < int'(ErrWidth); i++) ts_first_q[i] <= '0;
    end else if (clear_i) begin
      errored_q <= '0;
      pending_q <= '0;
      for (int i = 0; i < int'(ErrWidth); i++) ts_first_q[i] <= '0;
    end else begin
      errored_q <= errored_q | cheri_err_i;
      pending_q <= (pending_q & ~push_clr) | new_err;
      for (int i = 0; i < int'(ErrWidth); i++) begin
        if (new_err[i]) ts_first_q[i] <= ts_q;
      end
    end
  end

  prim_fifo_sync #(
    .Width (EvtW),
    .Pass  (1'b0),
    .Depth (FifoDepth)
  ) u_event_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clear_i),
    .wvalid_i (fifo_wvalid),
    .wready_o (fifo_wready),
    .wdata_i  ({push_idx, push_ts}),
    .rvalid_o (event_valid_o),
    .rready_i (event_ready_i),
    .rdata_o  (fifo_rdata)
  );

  assign event_idx_o = fifo_rdata[EvtW-1 -: IdxW];
  assign event_ts_o  = fifo_rdata[TsWidth-1:0];

  for (genvar g = 0; g < int'(ErrWidth); g++) begin : g_episode
    cheri_err_episode #(
      .CountWidth (CountWidth),
      .GapCycles  (GapCycles)
    ) u_episode (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .err_i   (cheri_err_i[g]),
      .count_o (count_o[g*CountWidth +: CountWidth])
    );
  end

  assign errored_o = errored_q;
  assign any_err_o = |errored_q;

endmodule

// File: tb/tb_cheri_err_monitor.sv
// Scoreboard bench for cheri_err_monitor (CountWidth=2, FifoDepth=2 to reach saturation and FIFO-full paths).
module tb_cheri_err_monitor;
  import cheri_err_pkg::*;

  localparam int EW = 9, TW = 48, CW = 2, GAP = 16, FD = 2, IW = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [EW-1:0]    cheri_err_i = '0;
  logic             clear_i = 1'b0;
  logic             event_ready_i = 1'b0;
  logic [EW-1:0]    errored_o;
  logic             any_err_o;
  logic [EW*CW-1:0] count_o;
  logic             event_valid_o;
  logic [IW-1:0]    event_idx_o;
  logic [TW-1:0]    event_ts_o;

  always #5 clk_i = ~clk_i;

  cheri_err_monitor #(
    .ErrWidth (EW), .TsWidth (TW), .CountWidth (CW), .GapCycles (GAP), .FifoDepth (FD)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cheri_err_i   (cheri_err_i),
    .clear_i       (clear_i),
    .errored_o     (errored_o),
    .any_err_o     (any_err_o),
    .count_o       (count_o),
    .event_valid_o (event_valid_o),
    .event_ready_i (event_ready_i),
    .event_idx_o   (event_idx_o),
    .event_ts_o    (event_ts_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int e);
    return count_o[e*CW +: CW];
  endfunction

  typedef struct {
    int          idx;
    logic [TW-1:0] ts;
  } exp_evt_t;

  exp_evt_t      exp_q [$];
  logic [TW-1:0] tb_ts;
  logic [EW-1:0] err_model;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tb_ts <= '0;
    else         tb_ts <= tb_ts + TW'(1);
  end

  // Inputs are stable here for the coming edge: check pops, then record new first occurrences.
  always @(negedge clk_i) begin
    exp_evt_t e;
    if (!rst_ni || clear_i) begin
      exp_q.delete();
      err_model = '0;
    end else begin
      if (event_valid_o && event_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("evt_unexpected_idx", 64'(event_idx_o), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq({"evt_idx_", CheriErrNames[e.idx]}, 64'(event_idx_o), 64'(e.idx));
          check_eq({"evt_ts_", CheriErrNames[e.idx]}, 64'(event_ts_o), 64'(e.ts));
        end
      end
      for (int i = 0; i < EW; i++) begin
        if (cheri_err_i[i] && !err_model[i]) begin
          err_model[i] = 1'b1;
          exp_q.push_back('{i, tb_ts});
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // 1: reset state, then idle
    step(3);
    check_eq("rst_errored", 64'(errored_o), 0);
    check_eq("rst_valid", 64'(event_valid_o), 0);
    check_eq("rst_count", 64'(count_o), 0);
    rst_ni = 1'b1;
    step(100);
    check_eq("idle_errored", 64'(errored_o), 0);
    check_eq("idle_any", 64'(any_err_o), 0);
    check_eq("idle_count", 64'(count_o), 0);
    check_eq("idle_valid", 64'(event_valid_o), 0);

    // 2: single-cycle pulse on bit 1 sampled at ts 100
    cheri_err_i = 9'h002;
    step();
    cheri_err_i = '0;
    check_eq("t2_lat_edge1_valid", 64'(event_valid_o), 0);
    step();
    check_eq("t2_valid", 64'(event_valid_o), 1);
    check_eq("t2_idx", 64'(event_idx_o), 1);
    check_eq("t2_ts", 64'(event_ts_o), 100);
    check_eq("t2_errored", 64'(errored_o), 64'h002);
    check_eq("t2_any", 64'(any_err_o), 1);
    check_eq("t2_cnt1", 64'(cnt(1)), 1);
    event_ready_i = 1'b1;
    step();
    check_eq("t2_popped_valid", 64'(event_valid_o), 0);
    step(20);
    cheri_err_i = 9'h002;
    step();
    cheri_err_i = '0;
    step(2);
    check_eq("t2_cnt1_second", 64'(cnt(1)), 2);
    check_eq("t2_no_new_event", 64'(event_valid_o), 0);

    // 3: modulated bit 0 is one episode until a long gap
    for (int i = 0; i < 10; i++) begin
      cheri_err_i = 9'h001;
      step(2);
      cheri_err_i = '0;
      step(2);
    end
    check_eq("t3_cnt0_modulated", 64'(cnt(0)), 1);
    check_eq("t3_one_event", 64'(exp_q.size()), 0);
    step(20);
    cheri_err_i = 9'h001;
    step();
    cheri_err_i = '0;
    step();
    check_eq("t3_cnt0_new_episode", 64'(cnt(0)), 2);

    pulse_clear();
    check_eq("clr_errored", 64'(errored_o), 0);
    check_eq("clr_count", 64'(count_o), 0);

    // 4: bits 0,3,8 rise together while consumer stalls
    event_ready_i = 1'b0;
    cheri_err_i = 9'h109;
    step(4);
    check_eq("t4_head_valid", 64'(event_valid_o), 1);
    check_eq("t4_head_idx", 64'(event_idx_o), 0);
    event_ready_i = 1'b1;
    step(3);
    check_eq("t4_drained_valid", 64'(event_valid_o), 0);
    check_eq("t4_sb_empty", 64'(exp_q.size()), 0);
    cheri_err_i = '0;

    // 5: more simultaneous events than FIFO entries
    pulse_clear();
    event_ready_i = 1'b0;
    cheri_err_i = 9'h01F;
    step(5);
    check_eq("t5_head_idx", 64'(event_idx_o), 0);
    event_ready_i = 1'b1;
    k = 0;
    while (event_valid_o && k < 20) begin
      step();
      k++;
    end
    check_eq("t5_drain_cycles", 64'(k), 5);
    check_eq("t5_none_lost", 64'(exp_q.size()), 0);
    cheri_err_i = '0;
    step(20);
    cheri_err_i = 9'h004;
    step();
    cheri_err_i = '0;
    step(20);
    check_eq("t5_cnt2_two", 64'(cnt(2)), 2);
    for (int i = 0; i < 4; i++) begin
      cheri_err_i = 9'h004;
      step();
      cheri_err_i = '0;
      step(20);
    end
    check_eq("t5_cnt2_saturated", 64'(cnt(2)), 3);

    // 6: clear with bit 5 held and events queued, then reset mid-drain
    pulse_clear();
    event_ready_i = 1'b0;
    cheri_err_i = 9'h060;
    step(4);
    check_eq("t6_queued_valid", 64'(event_valid_o), 1);
    cheri_err_i = 9'h020;
    pulse_clear();
    check_eq("t6_clr_valid", 64'(event_valid_o), 0);
    check_eq("t6_clr_errored", 64'(errored_o), 0);
    check_eq("t6_clr_count", 64'(count_o), 0);
    step();
    check_eq("t6_rereport_errored", 64'(errored_o), 64'h020);
    check_eq("t6_cnt5", 64'(cnt(5)), 1);
    step();
    check_eq("t6_rereport_idx", 64'(event_idx_o), 5);
    event_ready_i = 1'b1;
    step();
    cheri_err_i = 9'h00F;
    step(2);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_errored", 64'(errored_o), 0);
    check_eq("t6_rst_any", 64'(any_err_o), 0);
    check_eq("t6_rst_count", 64'(count_o), 0);
    check_eq("t6_rst_valid", 64'(event_valid_o), 0);
    cheri_err_i = '0;
    step(2);
    rst_ni = 1'b1;
    step(3);
    check_eq("t6_post_rst_valid", 64'(event_valid_o), 0);
    check_eq("final_sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
